// File: rtl/imem_loader_if.sv
// Bus bundle between the instruction-memory loader and its environment:
// load request, byte stream handshake, memory write port and CPU control.
interface imem_loader_if;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, len, rx_data, rx_valid,
        input  rx_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error
    );

    modport slave (
        input  start, len, rx_data, rx_valid,
        output rx_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Streams big-endian byte pairs into instruction memory while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before release.
module imem_loader (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RX_HI = 3'd1,
        RX_LO = 3'd2,
        WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
        CHK   = 3'd4,
`endif
        DONE  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [8:0]  load_len;
    logic [8:0]  word_cnt;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        cpu_hold;
    logic        in_chk;
    logic        xfer;
    logic        last_word;

    // A length byte of zero encodes a full 256-word image.
    function automatic logic [8:0] decode_len(input logic [7:0] l);
        return (l == 8'd0) ? 9'd256 : {1'b0, l};
    endfunction

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err;

    assign in_chk = (state == CHK);
`else
    assign in_chk = 1'b0;
`endif

    assign bus.rx_ready = (state == RX_HI) || (state == RX_LO) || in_chk;
    assign xfer         = bus.rx_valid && bus.rx_ready;
    assign last_word    = (word_cnt + 9'd1) == load_len;

    assign bus.im_we    = (state == WRITE);
    assign bus.im_addr  = addr;
    assign bus.im_wdata = wdata;
    assign bus.cpu_rst  = cpu_hold;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = RX_HI;
                end
            end
            RX_HI: begin
                if (xfer) begin
                    state_next = RX_LO;
                end
            end
            RX_LO: begin
                if (xfer) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = CHK;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = RX_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_next = (bus.rx_data == csum) ? DONE : IDLE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // DONE is only ever entered on a good load, so entering it releases the CPU.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_len <= 9'd0;
            word_cnt <= 9'd0;
            addr     <= 8'd0;
            wdata    <= 16'd0;
            cpu_hold <= 1'b1;
        end else begin
            if (state == IDLE && bus.start) begin
                load_len <= decode_len(bus.len);
                word_cnt <= 9'd0;
                addr     <= 8'd0;
                cpu_hold <= 1'b1;
            end
            if (state == RX_HI && xfer) begin
                wdata[15:8] <= bus.rx_data;
            end
            if (state == RX_LO && xfer) begin
                wdata[7:0] <= bus.rx_data;
            end
            if (state == WRITE) begin
                addr     <= addr + 8'd1;
                word_cnt <= word_cnt + 9'd1;
            end
            if (state != DONE && state_next == DONE) begin
                cpu_hold <= 1'b0;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= 8'd0;
            err  <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                csum <= 8'd0;
                err  <= 1'b0;
            end
            if ((state == RX_HI || state == RX_LO) && xfer) begin
                csum <= csum_add(csum, bus.rx_data);
            end
            if (state == CHK && xfer && bus.rx_data != csum) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.error = err;
`else
    assign bus.error = 1'b0;
`endif

endmodule
